// File: rtl/dtw_score_reducer.sv
// Drains one run of DTW scores from the sink FIFO and reduces them to a result record:
// best and second-best score, best position, confidence margin and threshold hit.
module dtw_score_reducer #(
  parameter int DWIDTH   = 32,
  parameter int FIFO_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DWIDTH-1:0] score_count,
  input  logic [DWIDTH-1:0] threshold,
  output logic              busy,
  output logic              src_fifo_rden,
  input  logic              src_fifo_empty,
  input  logic [DWIDTH-1:0] src_fifo_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DWIDTH-1:0] best_score,
  output logic [DWIDTH-1:0] best_pos,
  output logic [DWIDTH-1:0] second_score,
  output logic [DWIDTH-1:0] margin,
  output logic              hit
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [DWIDTH-1:0] ONE = DWIDTH'(1);

  state_e              state_q, state_d;
  logic [DWIDTH-1:0]   count_q, count_d;
  logic [DWIDTH-1:0]   thresh_q, thresh_d;
  logic [DWIDTH-1:0]   issued_q, issued_d;
  logic [DWIDTH-1:0]   received_q, received_d;
  logic [FIFO_LAT-1:0] vld_q, vld_d;
  logic [DWIDTH-1:0]   best_q, best_d;
  logic [DWIDTH-1:0]   second_q, second_d;
  logic [DWIDTH-1:0]   best_pos_q, best_pos_d;
  logic [DWIDTH-1:0]   margin_q, margin_d;
  logic                hit_q, hit_d;
  logic                rd_en;
  logic                data_vld;

  // NOTE: every variable assigned here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    thresh_d   = thresh_q;
    issued_d   = issued_q;
    received_d = received_q;
    best_d     = best_q;
    second_d   = second_q;
    best_pos_d = best_pos_q;
    margin_d   = margin_q;
    hit_d      = hit_q;

    rd_en    = (state_q == S_RUN) && !src_fifo_empty && (issued_q < count_q);
    data_vld = vld_q[FIFO_LAT-1];

    // Valid tag travels alongside the FIFO read latency so returning words are identified.
    vld_d[0] = rd_en;
    for (int i = 1; i < FIFO_LAT; i++) vld_d[i] = vld_q[i-1];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d    = score_count;
          thresh_d   = threshold;
          issued_d   = '0;
          received_d = '0;
          best_d     = '1;
          second_d   = '1;
          best_pos_d = '0;
          margin_d   = '0;
          hit_d      = 1'b0;
          state_d    = (score_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (rd_en) issued_d = issued_q + ONE;
        if (data_vld) begin
          if (src_fifo_data < best_q) begin
            second_d   = best_q;
            best_d     = src_fifo_data;
            best_pos_d = received_q;
          end else if (src_fifo_data < second_q) begin
            second_d = src_fifo_data;
          end
          received_d = received_q + ONE;
          // Last score: finalise from the just-updated values so DONE is entered directly.
          if (received_q == count_q - ONE) begin
            state_d  = S_DONE;
            margin_d = (second_d >= best_d) ? second_d - best_d : '0;
            hit_d    = (best_d < thresh_q);
          end
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      thresh_q   <= '0;
      issued_q   <= '0;
      received_q <= '0;
      vld_q      <= '0;
      best_q     <= '1;
      second_q   <= '1;
      best_pos_q <= '0;
      margin_q   <= '0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      thresh_q   <= thresh_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      vld_q      <= vld_d;
      best_q     <= best_d;
      second_q   <= second_d;
      best_pos_q <= best_pos_d;
      margin_q   <= margin_d;
      hit_q      <= hit_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign res_valid     = (state_q == S_DONE);
  assign src_fifo_rden = rd_en;
  assign best_score    = best_q;
  assign best_pos      = best_pos_q;
  assign second_score  = second_q;
  assign margin        = margin_q;
  assign hit           = hit_q;

endmodule

// File: tb/tb_dtw_score_reducer.sv
// Randomized self-checking bench for dtw_score_reducer: FIFO model with stalls and a
// two-pass min/second-min reference model.
module tb_dtw_score_reducer;

  localparam int DW  = 32;
  localparam int LAT = 1;
  localparam logic [DW-1:0] ONES = '1;

  typedef logic [DW-1:0] q_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] score_count = '0;
  logic [DW-1:0] threshold = '0;
  logic          busy;
  logic          src_fifo_rden;
  logic          src_fifo_empty = 1'b1;
  logic [DW-1:0] src_fifo_data;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] best_score, best_pos, second_score, margin;
  logic          hit;

  always #5 clk = ~clk;

  dtw_score_reducer #(.DWIDTH(DW), .FIFO_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .score_count(score_count), .threshold(threshold),
    .busy(busy), .src_fifo_rden(src_fifo_rden), .src_fifo_empty(src_fifo_empty),
    .src_fifo_data(src_fifo_data), .res_valid(res_valid), .res_ready(res_ready),
    .best_score(best_score), .best_pos(best_pos), .second_score(second_score),
    .margin(margin), .hit(hit)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO model: preloaded queue, data presented LAT cycles after a sampled rden.
  q_t            fifo_q;
  logic [DW-1:0] pipe [LAT];
  int            underflow = 0;
  assign src_fifo_data = pipe[LAT-1];

  always @(posedge clk) begin
    if (src_fifo_rden) begin
      if (fifo_q.size() == 0) underflow++;
      else pipe[0] <= fifo_q.pop_front();
    end
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  int empty_mode = 0;
  int emp_ctr = 0;
  always @(posedge clk) begin
    logic stall;
    #1;
    emp_ctr++;
    case (empty_mode)
      1:       stall = (emp_ctr % 6 == 0);
      2:       stall = ($urandom_range(3, 0) == 0);
      default: stall = 1'b0;
    endcase
    src_fifo_empty = stall || (fifo_q.size() == 0);
  end

  int cyc = 0;
  int rden_cnt = 0;
  int rden_empty_cnt = 0;
  int last_rden_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (src_fifo_rden) begin
      rden_cnt++;
      if (src_fifo_empty) rden_empty_cnt++;
      last_rden_cyc = cyc;
    end
  end

  // Reference: best = first index of the global minimum; second = minimum over the rest.
  task automatic model(input q_t s, input logic [DW-1:0] thr,
                       output logic [DW-1:0] e_best, output logic [DW-1:0] e_pos,
                       output logic [DW-1:0] e_second, output logic [DW-1:0] e_margin,
                       output logic e_hit);
    e_best = ONES;
    e_pos  = '0;
    foreach (s[i]) if (s[i] < e_best) begin e_best = s[i]; e_pos = DW'(i); end
    e_second = ONES;
    foreach (s[i]) if (DW'(i) != e_pos && s[i] < e_second) e_second = s[i];
    e_margin = e_second - e_best;
    e_hit    = (s.size() > 0) && (e_best < thr);
  endtask

  int start_cyc = 0;

  task automatic do_start(input logic [DW-1:0] cnt, input logic [DW-1:0] thr);
    @(posedge clk); #1;
    score_count = cnt;
    threshold   = thr;
    start       = 1'b1;
    start_cyc   = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int vcyc, output bit ok);
    ok   = 1'b0;
    vcyc = 0;
    for (int i = 0; i < 60000; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok   = 1'b1;
        vcyc = cyc;
        return;
      end
    end
    check("valid_timeout", 0, 1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    fifo_q.delete();
    empty_mode = 0;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_busy"},   DW'(busy), 0);
    check({tag, "_rden"},   DW'(src_fifo_rden), 0);
    check({tag, "_valid"},  DW'(res_valid), 0);
    check({tag, "_hit"},    DW'(hit), 0);
    check({tag, "_best"},   best_score, ONES);
    check({tag, "_second"}, second_score, ONES);
    check({tag, "_pos"},    best_pos, 0);
    check({tag, "_margin"}, margin, 0);
  endtask

  // One full run; hold > 0 keeps res_ready low that many cycles and pulses start meanwhile.
  task automatic run_case(input string tag, input q_t s, input logic [DW-1:0] thr,
                          input int mode, input int hold);
    logic [DW-1:0] e_best, e_pos, e_second, e_margin;
    logic          e_hit;
    int            r0, re0, u0, vc;
    bit            ok;
    model(s, thr, e_best, e_pos, e_second, e_margin, e_hit);
    r0  = rden_cnt;
    re0 = rden_empty_cnt;
    u0  = underflow;
    fifo_q     = s;
    empty_mode = mode;
    do_start(DW'(s.size()), thr);
    wait_valid(vc, ok);
    if (!ok) begin
      apply_reset();
      return;
    end
    check({tag, "_best"},   best_score, e_best);
    check({tag, "_pos"},    best_pos, e_pos);
    check({tag, "_second"}, second_score, e_second);
    check({tag, "_margin"}, margin, e_margin);
    check({tag, "_hit"},    DW'(hit), DW'(e_hit));
    check({tag, "_busy"},   DW'(busy), 1);
    check({tag, "_nrden"},  DW'(rden_cnt - r0), DW'(s.size()));
    check({tag, "_rd_while_empty"}, DW'(rden_empty_cnt - re0), 0);
    check({tag, "_underflow"}, DW'(underflow - u0), 0);
    if (s.size() > 0) check({tag, "_latency"}, DW'(vc), DW'(last_rden_cyc + LAT + 1));
    else              check({tag, "_latency"}, DW'(vc), DW'(start_cyc + 1));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      start = (i == 3);
      score_count = 5;
      @(negedge clk);
      check({tag, "_hold_valid"},  DW'(res_valid), 1);
      check({tag, "_hold_busy"},   DW'(busy), 1);
      check({tag, "_hold_best"},   best_score, e_best);
      check({tag, "_hold_second"}, second_score, e_second);
      check({tag, "_hold_margin"}, margin, e_margin);
    end
    @(posedge clk); #1;
    start     = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check({tag, "_post_valid"}, DW'(res_valid), 0);
    check({tag, "_post_busy"},  DW'(busy), 0);
    @(negedge clk);
    check({tag, "_idle_busy"},  DW'(busy), 0);
    empty_mode = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    q_t s;
    int r0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check_reset_state("reset");

    s = '{300, 50, 70, 50, 400};
    run_case("t1", s, 100, 0, 0);

    s = '{20, 30, 25, 40};
    run_case("t2", s, 10, 0, 0);

    s = {};
    run_case("count0", s, 100, 0, 0);

    s = '{1, 2};
    run_case("single_ones", '{DW'(123)}, 200, 0, 0);

    s = '{60, 15, 90};
    run_case("hold", s, 15, 0, 10);

    s = {};
    for (int i = 0; i < 29898; i++) s.push_back(DW'($urandom_range(32'hFFFF_FFFF, 8)));
    s[12345] = 7;
    run_case("long", s, 1000, 1, 0);

    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(40, 1);
      s = {};
      for (int i = 0; i < n; i++)
        s.push_back((k % 2 == 0) ? DW'($urandom_range(15, 0)) : DW'($urandom()));
      run_case($sformatf("rnd%0d", k), s, DW'($urandom_range(20, 0)), $urandom_range(2, 0), 0);
    end

    s = '{100, 200, 300, 400, 500, 600, 700, 800};
    r0 = rden_cnt;
    fifo_q = s;
    do_start(8, 50);
    for (int i = 0; i < 100 && (rden_cnt - r0) < 3; i++) @(negedge clk);
    repeat (LAT) @(negedge clk);
    apply_reset();
    check_reset_state("midrst");

    s = '{9, 8};
    run_case("after_rst", s, 20, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dtw_score_reducer.md
Name: dtw_score_reducer

Overview:
- Downstream of dtw_core: drains the 32-bit DTW score stream that dtw_core writes to its sink FIFO, one score per reference position, over a run of score_count entries.
- Tracks the best (minimum) and second-best scores and the best position, then computes a confidence margin and a threshold hit flag.
- Presents one result record per run on a valid/ready handshake toward the AXI-side readout logic.

Parameters:
- DWIDTH, 32, width of score words, positions and result fields.
- FIFO_LAT, 1, read latency in cycles from src_fifo_rden to valid src_fifo_data; legal values 1 and 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- start  in  1  one-cycle run request; sampled only in IDLE.
- score_count  in  DWIDTH  number of scores to consume; latched on accepted start.
- threshold  in  DWIDTH  match threshold; latched on accepted start.
- busy  out  1  high from accepted start until result handshake completes.
- src_fifo_rden  out  1  pop request to the score FIFO.
- src_fifo_empty  in  1  score FIFO empty.
- src_fifo_data  in  DWIDTH  score word, valid FIFO_LAT cycles after rden.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts the record.
- best_score  out  DWIDTH  minimum score seen.
- best_pos  out  DWIDTH  0-based index of best_score.
- second_score  out  DWIDTH  second-smallest score (index distinct from best_pos).
- margin  out  DWIDTH  second_score - best_score, saturating at 0.
- hit  out  1  best_score < threshold (strict).

Behaviour:
- Reset (rst=0 at a clock edge):
  - State = IDLE.
  - busy, src_fifo_rden, res_valid and hit = 0.
  - best_score and second_score = all-ones; best_pos and margin = 0.
  - Internal issue and receive counters and the in-flight pipeline are cleared.
  - Applies mid-run; in-flight FIFO data is discarded.
- States IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch score_count and threshold, set best and second to all-ones, clear counters, set busy=1.
  - Next state is RUN, or DONE if score_count = 0.
- RUN, reading:
  - src_fifo_rden = !src_fifo_empty && issued < count. It is combinational from registered state and the empty input.
  - Each rden increments issued.
  - A FIFO_LAT-deep valid shift register tags returning data.
- RUN, per returned score s at index received:
  - If s < best: second <= best, best <= s, best_pos <= received.
  - Else if s < second: second <= s.
  - Ties keep the earliest index for best; a score equal to best updates second.
  - received increments on each returned score.
- RUN to DONE:
  - Transition the cycle after received reaches count.
  - On entry, register margin = (second >= best) ? second - best : 0 and hit = (best < threshold).
  - With count = 1, second stays all-ones, so margin = all-ones - best.
- DONE:
  - res_valid = 1; all result outputs hold stable while res_valid=1 and res_ready=0.
  - On res_valid && res_ready: res_valid=0, busy=0, go to IDLE. The earliest new start is the following cycle.
- start while busy is ignored.
- score_count = 0: DONE is entered one cycle after start with best = all-ones, best_pos = 0, hit = 0, margin = 0.
- Latency: result valid = last rden + FIFO_LAT + 1 cycle.
- Empty toggling stalls reads only; no score is dropped or duplicated.

Test Plan:
- count=5, threshold=100, scores {300,50,70,50,400}, FIFO never empty -> best=50, best_pos=1, second=50, margin=0, hit=1, exactly 5 rden pulses.
- count=4, threshold=10, scores {20,30,25,40} -> best=20, best_pos=0, second=25, margin=5, hit=0.
- count=29898, random scores with a unique minimum 7 at index 12345, src_fifo_empty asserted 1 cycle in every 6 -> best=7, best_pos=12345, rden count = 29898, no rden while empty.
- count=0 -> res_valid one cycle after start, best=0xFFFFFFFF, hit=0, zero rden.
- Result complete with res_ready held low 10 cycles, a start pulse during the wait, then ready=1 -> outputs stable throughout, start ignored, busy falls with the handshake.
- Reset (rst=0) asserted after 3 of 8 scores, then a new run with count=2 {9,8} -> outputs at reset values, second run gives best=8, best_pos=1, second=9, margin=1.
